// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the pipeline controller.
//   regbits_t     : 5-bit register select
//   pctrl_state_t : halt-drain FSM state (RUN, DRAIN, HALTED)
//   DRAIN_W       : width of the drain counter
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } pctrl_state_t;

    localparam int DRAIN_W = 2;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counter.
//   CLK  : clock
//   RST  : synchronous active-high clear
//   inc  : count this cycle
//   cnt  : current count, sticks at all-ones
// Only part of the build when PIPE_PERF_CNT_EN is defined.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer paired with the hazard unit.
// Forwards stage-register fields to the hazard unit, converts its
// flush/stall plus cache hits into per-latch enable/flush strobes, and
// runs the halt-drain FSM (RUN -> DRAIN -> HALTED).
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   ihit, dhit, mem_req       cache hits, MEM-stage memory request
//   id_rs, id_rt, ex_rd       register selects from ID / EX
//   ex_memread, ex_halt,
//   ex_pc_mux, mem_datomic    stage flags
//   hz_flush, hz_stall        from hazard unit
//   hz_*                      to hazard unit (combinational pass-through)
//   pc_en, *_en, *_flush      latch enable / bubble strobes (flush wins)
//   halt_out                  registered, core halted
// Macro PIPE_PERF_CNT_EN adds stall_cnt, flush_cnt, bubble_cnt (CNT_W).
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W        = 32
`endif
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     mem_req,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  regbits_t ex_rd,
    input  logic     ex_memread,
    input  logic     ex_halt,
    input  logic     ex_pc_mux,
    input  logic     mem_datomic,
    input  logic     hz_flush,
    input  logic     hz_stall,
    output logic     hz_pc_mux,
    output logic     hz_memread,
    output logic     hz_halt,
    output logic     hz_datomic,
    output regbits_t hz_wsel,
    output regbits_t hz_rsel1,
    output regbits_t hz_rsel2,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     ifid_flush,
    output logic     idex_en,
    output logic     idex_flush,
    output logic     exmem_en,
    output logic     exmem_flush,
    output logic     memwb_en,
    output logic     halt_out
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    pctrl_state_t       state;
    logic [DRAIN_W-1:0] dcnt;
    logic               mem_stall;

    assign mem_stall  = mem_req & ~dhit;

    assign hz_wsel    = ex_rd;
    assign hz_rsel1   = id_rs;
    assign hz_rsel2   = id_rt;
    assign hz_memread = ex_memread;
    assign hz_pc_mux  = ex_pc_mux;
    assign hz_halt    = ex_halt;
    assign hz_datomic = mem_datomic;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= RUN;
            dcnt     <= '0;
            halt_out <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_halt && !mem_stall) begin
                        state <= DRAIN;
                        dcnt  <= DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    // A dcache miss freezes MEM/WB, so the count holds with it.
                    if (!mem_stall) begin
                        if (dcnt == '0) begin
                            state    <= HALTED;
                            halt_out <= 1'b1;
                        end else begin
                            dcnt <= dcnt - 1'b1;
                        end
                    end
                end
                HALTED: begin
                    halt_out <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        if (RST) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        // whole pipe frozen: all strobes stay low
                    end else if (hz_flush) begin
                        pc_en      = ihit;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (hz_stall) begin
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (!ihit) begin
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                DRAIN: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = ~mem_stall;
                    memwb_en   = ~mem_stall;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic run_cyc;
    logic stall_inc;
    logic flush_inc;
    logic bubble_inc;

    assign run_cyc    = (state == RUN) && !RST;
    assign stall_inc  = run_cyc && (mem_stall || (!hz_flush && hz_stall));
    assign flush_inc  = run_cyc && !mem_stall && hz_flush;
    assign bubble_inc = run_cyc && !mem_stall && !hz_flush && !hz_stall && !ihit;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (bubble_inc),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
// Strobe vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//                       exmem_en, exmem_flush, memwb_en}
module tb_pipeline_ctrl;

    logic       CLK;
    logic       RST;
    logic       ihit, dhit, mem_req;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       ex_memread, ex_halt, ex_pc_mux, mem_datomic;
    logic       hz_flush, hz_stall;
    logic       hz_pc_mux, hz_memread, hz_halt, hz_datomic;
    logic [4:0] hz_wsel, hz_rsel1, hz_rsel2;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, halt_out;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, bubble_cnt;
`endif

    logic [7:0]  strb;
    logic [18:0] hzv;
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [7:0] ALL_EN    = 8'b1101_0101;
    localparam logic [7:0] FREEZE    = 8'b0000_0000;
    localparam logic [7:0] FLUSH_P   = 8'b1010_1101;
    localparam logic [7:0] FLUSH_NOI = 8'b0010_1101;
    localparam logic [7:0] STALL_P   = 8'b0000_1101;
    localparam logic [7:0] MISS_P    = 8'b0011_0101;
    localparam logic [7:0] DRAIN_P   = 8'b0010_1101;
    localparam logic [7:0] DRAIN_FRZ = 8'b0010_1000;
    localparam logic [7:0] RST_P     = 8'b0010_1010;

    assign strb = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                   exmem_en, exmem_flush, memwb_en};
    assign hzv  = {hz_pc_mux, hz_memread, hz_halt, hz_datomic,
                   hz_wsel, hz_rsel1, hz_rsel2};

    pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .mem_req     (mem_req),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .ex_halt     (ex_halt),
        .ex_pc_mux   (ex_pc_mux),
        .mem_datomic (mem_datomic),
        .hz_flush    (hz_flush),
        .hz_stall    (hz_stall),
        .hz_pc_mux   (hz_pc_mux),
        .hz_memread  (hz_memread),
        .hz_halt     (hz_halt),
        .hz_datomic  (hz_datomic),
        .hz_wsel     (hz_wsel),
        .hz_rsel1    (hz_rsel1),
        .hz_rsel2    (hz_rsel2),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .exmem_flush (exmem_flush),
        .memwb_en    (memwb_en),
        .halt_out    (halt_out)
`ifdef PIPE_PERF_CNT_EN
      , .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0;
        id_rs = '0; id_rt = '0; ex_rd = '0;
        ex_memread = 1'b0; ex_halt = 1'b0; ex_pc_mux = 1'b0; mem_datomic = 1'b0;
        hz_flush = 1'b0; hz_stall = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        clear_inputs();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        clear_inputs();
        tick();
        tick();
        #1;
        n_checks++;
        if (strb !== RST_P) begin
            n_fail++;
            $display("FAIL reset_strobes got=%b want=%b", strb, RST_P);
        end
        n_checks++;
        if (halt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_halt got=%b want=0", halt_out);
        end
        ex_rd = 5'd17; id_rs = 5'd3; id_rt = 5'd29;
        ex_memread = 1'b1; ex_halt = 1'b1; ex_pc_mux = 1'b1; mem_datomic = 1'b1;
        #1;
        n_checks++;
        if (hzv !== {1'b1, 1'b1, 1'b1, 1'b1, 5'd17, 5'd3, 5'd29}) begin
            n_fail++;
            $display("FAIL hz_passthru got=%h want=%h", hzv,
                     {1'b1, 1'b1, 1'b1, 1'b1, 5'd17, 5'd3, 5'd29});
        end
        tick();
        RST = 1'b0;
        clear_inputs();
    endtask

    task automatic test_run();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (strb !== ALL_EN) begin
                n_fail++;
                $display("FAIL run_all_en cyc=%0d got=%b want=%b", i, strb, ALL_EN);
            end
        end
    endtask

    task automatic test_stall();
        tick();
        ex_rd = 5'd8; id_rs = 5'd8; hz_stall = 1'b1;
        #1;
        n_checks++;
        if (hz_wsel !== 5'd8 || hz_rsel1 !== 5'd8) begin
            n_fail++;
            $display("FAIL stall_sel got=%0d/%0d want=8/8", hz_wsel, hz_rsel1);
        end
        n_checks++;
        if (strb !== STALL_P) begin
            n_fail++;
            $display("FAIL stall_strobes got=%b want=%b", strb, STALL_P);
        end
        tick();
        hz_stall = 1'b0;
        #1;
        n_checks++;
        if (strb !== ALL_EN) begin
            n_fail++;
            $display("FAIL stall_release got=%b want=%b", strb, ALL_EN);
        end
        clear_inputs();
    endtask

    task automatic test_flush_wins();
        tick();
        hz_flush = 1'b1; hz_stall = 1'b1; ihit = 1'b1;
        #1;
        n_checks++;
        if (strb !== FLUSH_P) begin
            n_fail++;
            $display("FAIL flush_over_stall got=%b want=%b", strb, FLUSH_P);
        end
        ihit = 1'b0;
        #1;
        n_checks++;
        if (strb !== FLUSH_NOI) begin
            n_fail++;
            $display("FAIL flush_no_ihit got=%b want=%b", strb, FLUSH_NOI);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_icache_miss();
        tick();
        ihit = 1'b0;
        #1;
        n_checks++;
        if (strb !== MISS_P) begin
            n_fail++;
            $display("FAIL icache_miss got=%b want=%b", strb, MISS_P);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_dcache_freeze();
        tick();
        mem_req = 1'b1; dhit = 1'b0; hz_flush = 1'b1; ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (strb !== FREEZE) begin
                n_fail++;
                $display("FAIL dmiss_freeze cyc=%0d got=%b want=%b", i, strb, FREEZE);
            end
            tick();
        end
        dhit = 1'b1;
        #1;
        n_checks++;
        if (strb !== FLUSH_P) begin
            n_fail++;
            $display("FAIL dmiss_release got=%b want=%b", strb, FLUSH_P);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_halt_drain();
        tick();
        ex_halt = 1'b1;
        #1;
        n_checks++;
        if (strb !== ALL_EN) begin
            n_fail++;
            $display("FAIL halt_seen_run got=%b want=%b", strb, ALL_EN);
        end
        tick();                     // edge 1: DRAIN
        ex_halt = 1'b0;
        #1;
        n_checks++;
        if (strb !== DRAIN_P) begin
            n_fail++;
            $display("FAIL drain_strobes got=%b want=%b", strb, DRAIN_P);
        end
        tick();                     // edge 2
        tick();                     // edge 3
        n_checks++;
        if (halt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_early_halt got=%b want=0", halt_out);
        end
        tick();                     // edge 4: HALTED
        n_checks++;
        if (halt_out !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_halt_edge4 got=%b want=1", halt_out);
        end
        hz_flush = 1'b1; ex_halt = 1'b1;
        #1;
        n_checks++;
        if (strb !== FREEZE) begin
            n_fail++;
            $display("FAIL halted_strobes got=%b want=%b", strb, FREEZE);
        end
        tick();
        n_checks++;
        if (halt_out !== 1'b1) begin
            n_fail++;
            $display("FAIL halted_sticky got=%b want=1", halt_out);
        end

        do_reset();
        tick();
        ex_halt = 1'b1;
        tick();                     // edge 1: DRAIN, dcnt=2
        ex_halt = 1'b0;
        tick();                     // edge 2: dcnt=1
        mem_req = 1'b1; dhit = 1'b0;
        #1;
        n_checks++;
        if (strb !== DRAIN_FRZ) begin
            n_fail++;
            $display("FAIL drain_frozen got=%b want=%b", strb, DRAIN_FRZ);
        end
        tick();                     // edge 3: frozen, dcnt holds
        mem_req = 1'b0; dhit = 1'b1;
        tick();                     // edge 4: dcnt=0
        n_checks++;
        if (halt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_miss_edge4 got=%b want=0", halt_out);
        end
        tick();                     // edge 5: HALTED
        n_checks++;
        if (halt_out !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_miss_edge5 got=%b want=1", halt_out);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_drain();
        tick();
        ex_halt = 1'b1;
        tick();                     // DRAIN, dcnt=2
        ex_halt = 1'b0;
        tick();                     // dcnt=1
        RST = 1'b1;
        #1;
        n_checks++;
        if (strb !== RST_P) begin
            n_fail++;
            $display("FAIL mid_drain_rst_strobes got=%b want=%b", strb, RST_P);
        end
        tick();
        RST = 1'b0;
        n_checks++;
        if (halt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drain_rst_halt got=%b want=0", halt_out);
        end
        #1;
        n_checks++;
        if (strb !== ALL_EN) begin
            n_fail++;
            $display("FAIL mid_drain_back_to_run got=%b want=%b", strb, ALL_EN);
        end
`ifdef PIPE_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || bubble_cnt !== '0) begin
            n_fail++;
            $display("FAIL perf_cnt_cleared got=%0d/%0d/%0d want=0/0/0",
                     stall_cnt, flush_cnt, bubble_cnt);
        end
`endif
        tick();
        tick();
        tick();
        n_checks++;
        if (halt_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drain_no_halt got=%b want=0", halt_out);
        end
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_run();
        test_stall();
        test_flush_wins();
        test_icache_miss();
        test_dcache_freeze();
        test_halt_drain();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
